// File: rtl/vga_timing_pkg.sv
// VGA timing package: axis state encoding and 640x480@60 defaults.
// Shared by vga_axis_timer and vga_timing_gen.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        S_ACTIVE,
        S_FRONT,
        S_SYNC,
        S_BACK
    } axis_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter, segment FSM, wrap flag, sync/blank.
// Sync and blank are registered from next-state so they align with cnt.
module vga_axis_timer #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          sync,
    output logic          blank,
    output logic          blank_nxt
);
    import vga_timing_pkg::*;

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] F_BEG = CW'(ACTIVE);
    localparam logic [CW-1:0] S_BEG = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] B_BEG = CW'(ACTIVE + FP + SYNC);

    axis_state_t   state_q, state_d;
    logic [CW-1:0] cnt_d;
    logic          sync_d;

    assign wrap = (cnt == LAST);

    // Next count and segment; restart reloads the pre-frame position.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        if (restart) begin
            cnt_d   = LAST;
            state_d = S_BACK;
        end else if (step) begin
            cnt_d = wrap ? '0 : cnt + 1'b1;
            unique case (state_q)
                S_ACTIVE: if (cnt_d == F_BEG) state_d = S_FRONT;
                S_FRONT:  if (cnt_d == S_BEG) state_d = S_SYNC;
                S_SYNC:   if (cnt_d == B_BEG) state_d = S_BACK;
                S_BACK:   if (cnt_d == '0)    state_d = S_ACTIVE;
                default:  state_d = S_BACK;
            endcase
        end
        blank_nxt = (state_d != S_ACTIVE);
        sync_d    = (state_d == S_SYNC) ? POL : ~POL;
    end

    // Counter, state and level outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= LAST;
            state_q <= S_BACK;
            blank   <= 1'b1;
            sync    <= ~POL;
        end else begin
            cnt     <= cnt_d;
            state_q <= state_d;
            blank   <= blank_nxt;
            sync    <= sync_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock enable.
// Define VGA_FRAME_CNT_EN to add the frame_count output and counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int FRAME_W    = 8,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W       = $clog2(H_TOTAL),
    localparam int Y_W       = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           pix_ce,
    input  logic           restart,
    output logic [X_W-1:0] x_cnt,
    output logic [Y_W-1:0] y_cnt,
    output logic           h_sync,
    output logic           v_sync,
    output logic           de,
    output logic           h_blank,
    output logic           v_blank,
    output logic           line_start,
    output logic           frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_count
`endif
);

    logic adv;
    logic h_wrap, v_wrap;
    logic h_bn, v_bn;
    logic line_d, frame_d;

    assign adv     = en & pix_ce & ~restart;
    assign line_d  = adv & h_wrap;
    assign frame_d = line_d & v_wrap;

    vga_axis_timer #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL),
        .CW     (X_W)
    ) u_h (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .step      (adv),
        .cnt       (x_cnt),
        .wrap      (h_wrap),
        .sync      (h_sync),
        .blank     (h_blank),
        .blank_nxt (h_bn)
    );

    vga_axis_timer #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL),
        .CW     (Y_W)
    ) u_v (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .step      (line_d),
        .cnt       (y_cnt),
        .wrap      (v_wrap),
        .sync      (v_sync),
        .blank     (v_blank),
        .blank_nxt (v_bn)
    );

    // Data enable and one-clock line/frame strobes, aligned with counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= ~h_bn & ~v_bn;
            line_start  <= line_d;
            frame_start <= frame_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frames started, counted on the edge that raises frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (restart) begin
            frame_count <= '0;
        end else if (frame_d) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 and a tiny 7x6 raster.
// Frame counter checks run when VGA_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default 640x480 instance
    logic       d_rst = 1'b0, d_en = 1'b0, d_ce = 1'b0, d_rs = 1'b0;
    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_de, d_hb, d_vb, d_ls, d_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] d_fc;
`endif

    vga_timing_gen u_d (
        .clk         (clk),
        .rst         (d_rst),
        .en          (d_en),
        .pix_ce      (d_ce),
        .restart     (d_rs),
        .x_cnt       (d_x),
        .y_cnt       (d_y),
        .h_sync      (d_hs),
        .v_sync      (d_vs),
        .de          (d_de),
        .h_blank     (d_hb),
        .v_blank     (d_vb),
        .line_start  (d_ls),
        .frame_start (d_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (d_fc)
`endif
    );

    // Tiny 7x6 instance, positive h_sync
    logic       s_rst = 1'b0, s_en = 1'b0, s_ce = 1'b0, s_rs = 1'b0;
    logic [2:0] s_x, s_y;
    logic       s_hs, s_vs, s_de, s_hb, s_vb, s_ls, s_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [1:0] s_fc;
`endif

    vga_timing_gen #(
        .H_ACTIVE   (4),
        .H_FP       (1),
        .H_SYNC     (1),
        .H_BP       (1),
        .V_ACTIVE   (3),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .H_SYNC_POL (1'b1),
        .V_SYNC_POL (1'b0),
        .FRAME_W    (2)
    ) u_s (
        .clk         (clk),
        .rst         (s_rst),
        .en          (s_en),
        .pix_ce      (s_ce),
        .restart     (s_rs),
        .x_cnt       (s_x),
        .y_cnt       (s_y),
        .h_sync      (s_hs),
        .v_sync      (s_vs),
        .de          (s_de),
        .h_blank     (s_hb),
        .v_blank     (s_vb),
        .line_start  (s_ls),
        .frame_start (s_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (s_fc)
`endif
    );

    initial begin
        int hs_low, hs_first, hs_last, de_n, ls_n, fs_n, bad;
        int hs_act, vs_low, prev, c, rises, hi_n, t_rise, per, pfs;
`ifdef VGA_FRAME_CNT_EN
        int fc_exp;
`endif
        #2;
        d_rst = 1'b1;
        s_rst = 1'b1;
        repeat (3) tick();

        check("d_rst_x", d_x, 799);
        check("d_rst_y", d_y, 524);
        check("d_rst_de", d_de, 0);
        check("d_rst_hb", d_hb, 1);
        check("d_rst_vb", d_vb, 1);
        check("d_rst_hs", d_hs, 1);
        check("d_rst_vs", d_vs, 1);
        check("d_rst_ls", d_ls, 0);
        check("d_rst_fs", d_fs, 0);

        d_rst = 1'b0;
        d_en  = 1'b1;
        d_ce  = 1'b1;
        tick();
        check("d_first_x", d_x, 0);
        check("d_first_y", d_y, 0);
        check("d_first_de", d_de, 1);
        check("d_first_ls", d_ls, 1);
        check("d_first_fs", d_fs, 1);

        hs_low = 0; hs_first = -1; hs_last = -1;
        de_n = 0; ls_n = 0; fs_n = 0; bad = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            if (!d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(d_x);
                hs_last = int'(d_x);
            end
            de_n += int'(d_de);
            ls_n += int'(d_ls);
            fs_n += int'(d_fs);
            if (d_hb != (d_x >= 640) || d_de != (d_x < 640)) bad++;
        end
        check("line_hs_low", hs_low, 96);
        check("line_hs_first", hs_first, 656);
        check("line_hs_last", hs_last, 751);
        check("line_de", de_n, 640);
        check("line_ls", ls_n, 1);
        check("line_fs", fs_n, 1);
        check("line_coherent", bad, 0);

        tick();
        check("line2_x", d_x, 0);
        check("line2_y", d_y, 1);
        check("line2_ls", d_ls, 1);
        check("line2_fs", d_fs, 0);

        repeat (100) tick();
        check("pre_freeze_x", d_x, 100);
        d_en = 1'b0;
        bad = 0;
        repeat (50) begin
            tick();
            if (d_x != 100 || d_ls || d_fs) bad++;
        end
        check("freeze_hold", bad, 0);
        d_en = 1'b1;
        tick();
        check("unfreeze_x", d_x, 101);

        bad = 0;
        for (int i = 0; i < 40; i++) begin
            prev = int'(d_x);
            c = (i % 4 == 0) ? 1 : 0;
            d_ce = (c == 1);
            tick();
            if (int'(d_x) != prev + c) bad++;
        end
        check("pace_steps", bad, 0);
        check("pace_x", d_x, 111);

        d_ce = 1'b1;
        repeat (189) tick();
        check("pre_rs_x", d_x, 300);
        d_rs = 1'b1;
        tick();
        check("rs_x", d_x, 799);
        check("rs_y", d_y, 524);
        check("rs_de", d_de, 0);
        check("rs_hb", d_hb, 1);
        check("rs_vb", d_vb, 1);
        check("rs_hs", d_hs, 1);
        check("rs_vs", d_vs, 1);
        check("rs_fs", d_fs, 0);
        d_rs = 1'b0;
        tick();
        check("post_rs_x", d_x, 0);
        check("post_rs_y", d_y, 0);
        check("post_rs_fs", d_fs, 1);
        check("post_rs_de", d_de, 1);

        check("s_rst_x", s_x, 6);
        check("s_rst_y", s_y, 5);
        check("s_rst_hs", s_hs, 0);
        check("s_rst_vs", s_vs, 1);
        check("s_rst_de", s_de, 0);
`ifdef VGA_FRAME_CNT_EN
        check("s_rst_fc", s_fc, 0);
`endif
        s_rst = 1'b0;
        s_en  = 1'b1;
        s_ce  = 1'b1;

        de_n = 0; hs_act = 0; vs_low = 0; ls_n = 0; fs_n = 0;
        for (int i = 0; i < 42; i++) begin
            tick();
            if (i == 0) begin
                check("s_first_fs", s_fs, 1);
                check("s_first_xy", int'({s_x, s_y}), 0);
`ifdef VGA_FRAME_CNT_EN
                check("s_first_fc", s_fc, 1);
`endif
            end
            de_n   += int'(s_de);
            hs_act += int'(s_hs);
            vs_low += int'(!s_vs);
            ls_n   += int'(s_ls);
            fs_n   += int'(s_fs);
        end
        check("s_frame_de", de_n, 12);
        check("s_frame_hs", hs_act, 6);
        check("s_frame_vs", vs_low, 7);
        check("s_frame_ls", ls_n, 6);
        check("s_frame_fs", fs_n, 1);
        tick();
        check("s_wrap_x", s_x, 0);
        check("s_wrap_y", s_y, 0);
        check("s_wrap_fs", s_fs, 1);

`ifdef VGA_FRAME_CNT_EN
        check("s_fc_2", s_fc, 2);
        fc_exp = 2;
        for (int i = 0; i < 126; i++) begin
            tick();
            if (s_fs) begin
                fc_exp = (fc_exp + 1) % 4;
                check("s_fc_seq", s_fc, fc_exp);
            end
        end
`endif

        rises = 0; hi_n = 0; t_rise = -1; per = 0; pfs = 0;
        for (int i = 0; i < 360; i++) begin
            s_ce = (i % 4 == 0);
            tick();
            hi_n += int'(s_fs);
            if (s_fs && pfs == 0) begin
                rises++;
                if (t_rise >= 0) per = i - t_rise;
                t_rise = i;
            end
            pfs = int'(s_fs);
        end
        check("pace_fs_rises", rises, 2);
        check("pace_fs_width", hi_n, 2);
        check("pace_fs_period", per, 168);

        s_ce = 1'b1;
        repeat (3) tick();
        #3;
        s_rst = 1'b1;
        #1;
        check("arst_x", s_x, 6);
        check("arst_y", s_y, 5);
        check("arst_hs", s_hs, 0);
        check("arst_vs", s_vs, 1);
        check("arst_de", s_de, 0);
        check("arst_ls", s_ls, 0);
`ifdef VGA_FRAME_CNT_EN
        check("arst_fc", s_fc, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
